length_frame_arbiter: RTL and testbench

LENGTH_FRAME_ARBITER -- requirements
Module: length_frame_arbiter

---
 rtl/tsn_arb_pkg.sv | 34 +++
 rtl/length_frame_arbiter_if.sv | 32 +++
 rtl/axis_reg_slice.sv | 53 +++++
 rtl/length_frame_arbiter.sv | 102 ++++++++++
 tb/tb_length_frame_arbiter.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/tsn_arb_pkg.sv
// rtl/tsn_arb_pkg.sv - shared arbiter state encoding and round-robin search
package tsn_arb_pkg;

  localparam int MAX_PORTS = 8;
  localparam int MAX_IDX_W = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_t;

  // First set bit of req at or after (last+1) mod n, wrapping; n <= MAX_PORTS.
  // Returns last unchanged when req is empty (caller only uses it when |req).
  function automatic logic [MAX_IDX_W-1:0] rr_search(
    input logic [MAX_PORTS-1:0] req,
    input logic [MAX_IDX_W-1:0] last,
    input int                   n
  );
    logic [MAX_IDX_W-1:0] pick;
    logic [MAX_IDX_W-1:0] cand;
    logic                 found;
    pick  = last;
    found = 1'b0;
    for (int i = 1; i <= MAX_PORTS; i++) begin
      cand = MAX_IDX_W'((int'(last) + i) % n);
      if (i <= n && !found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/length_frame_arbiter_if.sv
// rtl/length_frame_arbiter_if.sv - stream bundle: NUM_PORTS inputs merged into one output
//   s_axis_tdata  [NUM_PORTS*DATA_WIDTH]  port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   s_axis_tvalid/tready/tlast [NUM_PORTS] per-port handshake and frame end
//   m_axis_tdata/tvalid/tready/tlast/tdest merged stream, tdest = source port
interface length_frame_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_PORTS  = 4
);
  localparam int DEST_W = $clog2(NUM_PORTS);

  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata;
  logic [NUM_PORTS-1:0]            s_axis_tvalid;
  logic [NUM_PORTS-1:0]            s_axis_tready;
  logic [NUM_PORTS-1:0]            s_axis_tlast;
  logic [DATA_WIDTH-1:0]           m_axis_tdata;
  logic                            m_axis_tvalid;
  logic                            m_axis_tready;
  logic                            m_axis_tlast;
  logic [DEST_W-1:0]               m_axis_tdest;

  // The arbiter sits on the slave side of the bundle.
  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tdest
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tdest
  );

endinterface

// File: rtl/axis_reg_slice.sv
// rtl/axis_reg_slice.sv - 2-entry register slice (output register + skid register)
//   clk, rstn                  clock, async active-low reset
//   i_valid/o_ready/i_data     upstream side
//   o_valid/i_ready/o_data     downstream side, fully registered
module axis_reg_slice #(
  parameter int WIDTH = 11
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data
);

  logic             r_out_valid;
  logic             r_skid_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [WIDTH-1:0] r_skid_data;

  // Ready depends only on the skid register, so no combinational path
  // from i_ready back to o_ready.
  assign o_ready = ~r_skid_valid;
  assign o_valid = r_out_valid;
  assign o_data  = r_out_data;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_out_data   <= '0;
      r_skid_data  <= '0;
    end else if (i_ready || !r_out_valid) begin
      if (r_skid_valid) begin
        r_out_data   <= r_skid_data;
        r_out_valid  <= 1'b1;
        r_skid_valid <= 1'b0;
      end else begin
        r_out_valid <= i_valid;
        if (i_valid) begin
          r_out_data <= i_data;
        end
      end
    end else if (i_valid && !r_skid_valid) begin
      // Output stalled: park the accepted beat in the skid register.
      r_skid_valid <= 1'b1;
      r_skid_data  <= i_data;
    end
  end

endmodule

// File: rtl/length_frame_arbiter.sv
// rtl/length_frame_arbiter.sv - frame-atomic round-robin merge of NUM_PORTS streams
//   clk, rstn    clock, async active-low reset
//   bus          length_frame_arbiter_if.slave (s_axis_* inputs, m_axis_* output)
//   frame_count  frames completed on m_axis, wraps at 2^CNT_WIDTH
module length_frame_arbiter
  import tsn_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_PORTS  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  length_frame_arbiter_if.slave bus,
  output logic [CNT_WIDTH-1:0]  frame_count
);

  localparam int DEST_W  = $clog2(NUM_PORTS);
  localparam int SLICE_W = DATA_WIDTH + 1 + DEST_W;

  arb_state_t             r_state;
  logic [DEST_W-1:0]      r_grant;
  logic [DEST_W-1:0]      r_last_grant;
  logic [CNT_WIDTH-1:0]   r_frame_count;

  logic                   w_in_valid;
  logic                   w_in_ready;
  logic                   w_in_last;
  logic                   w_accept;
  logic [DATA_WIDTH-1:0]  w_in_data;
  logic [NUM_PORTS-1:0]   w_tready;
  logic [DEST_W-1:0]      w_next_grant;
  logic                   w_out_valid;
  logic [SLICE_W-1:0]     w_out_payload;

  assign w_in_valid = (r_state == ST_BUSY) && bus.s_axis_tvalid[r_grant];
  assign w_in_data  = bus.s_axis_tdata[r_grant*DATA_WIDTH +: DATA_WIDTH];
  assign w_in_last  = bus.s_axis_tlast[r_grant];
  assign w_accept   = w_in_valid && w_in_ready;

  always_comb begin
    w_tready = '0;
    if (r_state == ST_BUSY) begin
      w_tready[r_grant] = w_in_ready;
    end
  end
  assign bus.s_axis_tready = w_tready;

  assign w_next_grant = DEST_W'(rr_search(MAX_PORTS'(bus.s_axis_tvalid),
                                          MAX_IDX_W'(r_last_grant), NUM_PORTS));

  // Requests are only sampled in IDLE; a frame always costs one IDLE cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= ST_IDLE;
      r_grant      <= '0;
      r_last_grant <= DEST_W'(NUM_PORTS - 1);
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|bus.s_axis_tvalid) begin
            r_grant <= w_next_grant;
            r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (w_accept && w_in_last) begin
            r_state      <= ST_IDLE;
            r_last_grant <= r_grant;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  axis_reg_slice #(
    .WIDTH (SLICE_W)
  ) u_slice (
    .clk     (clk),
    .rstn    (rstn),
    .i_valid (w_in_valid),
    .o_ready (w_in_ready),
    .i_data  ({r_grant, w_in_last, w_in_data}),
    .o_valid (w_out_valid),
    .i_ready (bus.m_axis_tready),
    .o_data  (w_out_payload)
  );

  assign bus.m_axis_tvalid = w_out_valid;
  assign {bus.m_axis_tdest, bus.m_axis_tlast, bus.m_axis_tdata} = w_out_payload;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_frame_count <= '0;
    end else if (w_out_valid && bus.m_axis_tready && bus.m_axis_tlast) begin
      r_frame_count <= r_frame_count + CNT_WIDTH'(1);
    end
  end
  assign frame_count = r_frame_count;

endmodule

// File: tb/tb_length_frame_arbiter.sv
// tb/tb_length_frame_arbiter.sv - randomized bench for length_frame_arbiter with round-robin reference model
module tb_length_frame_arbiter;

  localparam int DW  = 8;
  localparam int NP  = 4;
  localparam int CW  = 4;
  localparam int DSW = 2;

  logic          clk  = 1'b0;
  logic          rstn = 1'b1;
  logic [CW-1:0] frame_count;

  always #5 clk = ~clk;

  length_frame_arbiter_if #(.DATA_WIDTH(DW), .NUM_PORTS(NP)) bus ();

  length_frame_arbiter #(
    .DATA_WIDTH (DW),
    .NUM_PORTS  (NP),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .bus         (bus),
    .frame_count (frame_count)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Per-port beat store {tlast, tdata}, expected output {tdest, tlast, tdata}.
  logic [DW:0]      mem   [NP][512];
  int               wr_p  [NP];
  int               rd_p  [NP];
  int               gap   [NP];
  bit               first [NP];
  logic [DW+DSW:0]  exp_q [4096];
  int               exp_wr = 0, exp_rd = 0;
  int               ord   [512];
  int               ord_wr = 0, ord_in = 0;
  int               model_last = NP - 1;
  int               model_fc = 0;
  int               cyc = 0, prev_cyc = 0;
  int               rmode = 0;
  bit               gaps = 0, strict = 0, any_frame = 0, out_sof = 1;
  logic             stalled = 1'b0;
  logic [DW+DSW:0]  held;

  task automatic cycle();
    logic [NP-1:0]   hs;
    logic [DW+DSW:0] beat;
    @(negedge clk);
    cyc++;
    hs = bus.s_axis_tvalid & bus.s_axis_tready;
    check("tready_onehot", 32'($countones(bus.s_axis_tready) <= 1), 1);
    for (int p = 0; p < NP; p++) begin
      if (hs[p]) begin
        check("in_port", p, (ord_in < ord_wr) ? ord[ord_in] : -1);
        if (bus.s_axis_tlast[p]) ord_in++;
      end
    end
    check("frame_count", frame_count, model_fc);
    beat = {bus.m_axis_tdest, bus.m_axis_tlast, bus.m_axis_tdata};
    if (stalled) check("hold_stable", beat, held);
    stalled = bus.m_axis_tvalid && !bus.m_axis_tready;
    held    = beat;
    if (bus.m_axis_tvalid && bus.m_axis_tready) begin
      if (exp_rd >= exp_wr) begin
        check("extra_beat", 1, 0);
      end else begin
        check("tdata", bus.m_axis_tdata, exp_q[exp_rd][DW-1:0]);
        check("tlast", bus.m_axis_tlast, exp_q[exp_rd][DW]);
        check("tdest", bus.m_axis_tdest, exp_q[exp_rd][DW+DSW:DW+1]);
        if (strict && any_frame) check("spacing", cyc - prev_cyc, out_sof ? 2 : 1);
        exp_rd++;
      end
      any_frame = 1;
      prev_cyc  = cyc;
      out_sof   = bus.m_axis_tlast;
      if (bus.m_axis_tlast) model_fc = (model_fc + 1) % (1 << CW);
    end
    @(posedge clk);
    #1;
    for (int p = 0; p < NP; p++) begin
      if (hs[p]) begin
        first[p] = mem[p][rd_p[p]][DW];
        rd_p[p]++;
      end
      if (!(bus.s_axis_tvalid[p] && !hs[p])) begin
        if (rd_p[p] < wr_p[p]) begin
          if (gap[p] > 0) begin
            gap[p]--;
            bus.s_axis_tvalid[p] = 1'b0;
          end else if (gaps && !first[p] && $urandom_range(0, 3) == 0) begin
            gap[p] = 4;
            bus.s_axis_tvalid[p] = 1'b0;
          end else begin
            bus.s_axis_tvalid[p]          = 1'b1;
            bus.s_axis_tdata[p*DW +: DW]  = mem[p][rd_p[p]][DW-1:0];
            bus.s_axis_tlast[p]           = mem[p][rd_p[p]][DW];
          end
        end else begin
          bus.s_axis_tvalid[p] = 1'b0;
        end
      end
    end
    case (rmode)
      0:       bus.m_axis_tready = 1'b1;
      1:       bus.m_axis_tready = ~bus.m_axis_tready;
      default: bus.m_axis_tready = ($urandom_range(0, 9) < 7);
    endcase
  endtask

  // Loads frames (length beat + payload) and predicts the merged output:
  // whole frames, ports taken round-robin from the one after the last served.
  task automatic plan_round(input logic [NP-1:0] ports, input int nfr, input int lmin,
                            input int lmax, input int rm, input bit gp, input bit st);
    int pend [NP];
    int pr   [NP];
    int len, sel;
    bit found, more;
    rmode = rm; gaps = gp; strict = st; any_frame = 0; out_sof = 1;
    for (int p = 0; p < NP; p++) begin
      wr_p[p] = 0; rd_p[p] = 0; pr[p] = 0; pend[p] = 0; gap[p] = 0; first[p] = 1;
      if (ports[p]) begin
        for (int f = 0; f < nfr; f++) begin
          len = $urandom_range(lmin, lmax);
          mem[p][wr_p[p]] = {1'b0, DW'(len)};
          wr_p[p]++;
          for (int b = 0; b < len; b++) begin
            mem[p][wr_p[p]] = {(b == len - 1), DW'($urandom)};
            wr_p[p]++;
          end
          pend[p]++;
        end
      end
    end
    more = 1;
    while (more) begin
      found = 0;
      sel   = 0;
      for (int i = 1; i <= NP; i++) begin
        if (!found && pend[(model_last + i) % NP] > 0) begin
          found = 1;
          sel   = (model_last + i) % NP;
        end
      end
      if (!found) begin
        more = 0;
      end else begin
        ord[ord_wr] = sel;
        ord_wr++;
        do begin
          exp_q[exp_wr] = {DSW'(sel), mem[sel][pr[sel]]};
          exp_wr++;
          pr[sel]++;
        end while (!mem[sel][pr[sel]-1][DW]);
        pend[sel]--;
        model_last = sel;
      end
    end
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_rd < exp_wr && guard < 4000) begin
      cycle();
      guard++;
    end
    check("drain_done", exp_rd, exp_wr);
    repeat (3) cycle();
  endtask

  task automatic run_round(input logic [NP-1:0] ports, input int nfr, input int lmin,
                           input int lmax, input int rm, input bit gp, input bit st);
    plan_round(ports, nfr, lmin, lmax, rm, gp, st);
    drain();
  endtask

  initial begin
    bus.s_axis_tdata  = '0;
    bus.s_axis_tvalid = '0;
    bus.s_axis_tlast  = '0;
    bus.m_axis_tready = 1'b0;
    #2 rstn = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_m_tvalid", bus.m_axis_tvalid, 0);
    check("rst_m_tlast", bus.m_axis_tlast, 0);
    check("rst_m_tdata", bus.m_axis_tdata, 0);
    check("rst_m_tdest", bus.m_axis_tdest, 0);
    check("rst_s_tready", bus.s_axis_tready, 0);
    check("rst_frame_count", frame_count, 0);
    @(posedge clk);
    #1 rstn = 1'b1;

    run_round(4'b0001, 1, 64, 64, 0, 0, 1);
    run_round(4'b1111, 2, 2, 2, 0, 0, 1);
    run_round(4'b0100, 3, 5, 12, 1, 0, 0);
    run_round(4'b1010, 2, 8, 15, 0, 1, 0);
    run_round(4'b0010, 4, 1, 3, 0, 0, 1);
    for (int r = 0; r < 6; r++) begin
      run_round(NP'($urandom_range(1, 15)), $urandom_range(1, 3), 1, 10, 2, 1, 0);
    end

    plan_round(4'b0100, 1, 30, 30, 0, 0, 0);
    repeat (10) cycle();
    #2 rstn = 1'b0;
    #1;
    check("midrst_m_tvalid", bus.m_axis_tvalid, 0);
    check("midrst_frame_count", frame_count, 0);
    check("midrst_s_tready", bus.s_axis_tready, 0);
    bus.s_axis_tvalid = '0;
    for (int p = 0; p < NP; p++) begin
      rd_p[p] = wr_p[p]; gap[p] = 0; first[p] = 1;
    end
    exp_rd = exp_wr; ord_in = ord_wr;
    model_last = NP - 1; model_fc = 0; stalled = 1'b0;
    repeat (2) cycle();
    rstn = 1'b1;
    run_round(4'b0101, 1, 2, 6, 0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
